uncached_store_buffer: RTL

UNCACHED_STORE_BUFFER -- requirements
Module: uncached_store_buffer

---
 rtl/uncached_store_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uncached_store_buffer.sv
// Uncached store buffer: queues d_cache uncached stores and drains them one at a
// time as single-beat AXI writes, with an address probe for load hazard checks.
module uncached_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_strb,
  input  logic [2:0]  st_size,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] WAIT_B = 2'd2;

  logic [31:0]   addrMem [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [3:0]    strbMem [DEPTH];
  logic [2:0]    sizeMem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          awDone_q, awDone_d;
  logic          wDone_q, wDone_d;

  logic push, pop, awFire, wFire;

  // A full buffer refuses stores even if the head pops in the same cycle.
  assign st_ready = (count_q < CW'(DEPTH));
  assign push     = st_valid & st_ready;
  assign pop      = (state_q == WAIT_B) & bvalid;

  assign awvalid = (state_q == SEND) & ~awDone_q;
  assign wvalid  = (state_q == SEND) & ~wDone_q;
  assign bready  = (state_q == WAIT_B);
  assign awFire  = awvalid & awready;
  assign wFire   = wvalid & wready;

  assign awaddr = addrMem[rdPtr_q];
  assign awsize = sizeMem[rdPtr_q];
  assign awlen  = 8'd0;
  assign wdata  = dataMem[rdPtr_q];
  assign wstrb  = strbMem[rdPtr_q];
  assign wlast  = 1'b1;

  assign empty = (count_q == '0) & (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d  = SEND;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
        end
      end
      SEND: begin
        awDone_d = awDone_q | awFire;
        wDone_d  = wDone_q | wFire;
        if (awDone_d && wDone_d) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PW'(1) : rdPtr_q;
  end

  // The in-flight head stays occupied until its B response pops it.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (addrMem[rdPtr_q + PW'(i)][31:2] == chk_addr[31:2])) begin
        chk_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr_q] <= st_addr;
      dataMem[wrPtr_q] <= st_data;
      strbMem[wrPtr_q] <= st_strb;
      sizeMem[wrPtr_q] <= st_size;
    end
  end

endmodule
